// File: rtl/gate_pkg.sv
// Shared MODE encoding for the gate array pipeline.
package gate_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_AND  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_OR   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_XOR  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_NAND = 3'd3;
  localparam logic [MODE_W-1:0] MODE_NOR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

endpackage

// File: rtl/gate_array_pipe_if.sv
// Operand/result handshake bundle for gate_array_pipe.
interface gate_array_pipe_if #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  parameter int CNT_W = 16
) ();

  logic [N_IN*WIDTH-1:0]      a;
  logic [gate_pkg::MODE_W-1:0] mode;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           y;
  logic                       illegal;
  logic                       out_valid;
  logic                       out_ready;
  logic [CNT_W-1:0]           count;

  modport master (
    output a, mode, in_valid, out_ready,
    input  in_ready, y, illegal, out_valid, count
  );

  modport slave (
    input  a, mode, in_valid, out_ready,
    output in_ready, y, illegal, out_valid, count
  );

endinterface

// File: rtl/gate_pipe_stage.sv
// One valid/ready register slice; loads when empty or when its content leaves this cycle.
module gate_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/gate_array_pipe.sv
// Two-stage pipelined N_IN-way bitwise reducer with a delivered-result counter.
module gate_array_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  gate_array_pipe_if.slave bus
);

  localparam int S1_W = MODE_W + N_IN*WIDTH;
  localparam int S2_W = WIDTH + 1;

  logic              s1_valid;
  logic              s1_ready;
  logic [S1_W-1:0]   s1_data;
  logic [MODE_W-1:0] s1_mode;
  logic [N_IN*WIDTH-1:0] s1_a;
  logic [S2_W-1:0]   s2_data;
  logic [WIDTH-1:0]  and_r, or_r, xor_r, red_y;
  logic              red_illegal;
  logic [CNT_W-1:0]  cnt;

  gate_pipe_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_data   ({bus.mode, bus.a}),
    .in_ready  (bus.in_ready),
    .out_valid (s1_valid),
    .out_data  (s1_data),
    .out_ready (s1_ready)
  );

  assign s1_mode = s1_data[S1_W-1 -: MODE_W];
  assign s1_a    = s1_data[N_IN*WIDTH-1:0];

  // Full N-way folds first; the inverted modes complement the whole fold.
  always_comb begin
    and_r       = '1;
    or_r        = '0;
    xor_r       = '0;
    red_y       = '0;
    red_illegal = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      and_r = and_r & s1_a[k*WIDTH +: WIDTH];
      or_r  = or_r  | s1_a[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ s1_a[k*WIDTH +: WIDTH];
    end
    case (s1_mode)
      MODE_AND:  red_y = and_r;
      MODE_OR:   red_y = or_r;
      MODE_XOR:  red_y = xor_r;
      MODE_NAND: red_y = ~and_r;
      MODE_NOR:  red_y = ~or_r;
      MODE_XNOR: red_y = ~xor_r;
      default:   red_illegal = 1'b1;
    endcase
  end

  gate_pipe_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_data   ({red_illegal, red_y}),
    .in_ready  (s1_ready),
    .out_valid (bus.out_valid),
    .out_data  (s2_data),
    .out_ready (bus.out_ready)
  );

  assign bus.y       = s2_data[WIDTH-1:0];
  assign bus.illegal = s2_data[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.count = cnt;

endmodule
